// File: rtl/pipe_hazard_unit_if.sv
// Decode-stage hazard interface: ID instruction fields in, pipeline control,
// forwarding selects and performance counters out.
interface pipe_hazard_unit_if #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned FWD_STAGES = 3,
  parameter int unsigned CNT_W      = 32
);
  localparam int unsigned FSW = $clog2(FWD_STAGES + 1);

  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_branch_tk;

  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              idex_bubble;
  logic              stall;
  logic [FSW-1:0]    fwd_sel_a;
  logic [FSW-1:0]    fwd_sel_b;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write,
           id_mem_read, id_branch_tk,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, stall, fwd_sel_a, fwd_sel_b,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write,
           id_mem_read, id_branch_tk,
    output pc_write, ifid_write, ifid_flush, idex_bubble, stall, fwd_sel_a, fwd_sel_b,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller: scoreboard of in-flight destinations behind ID,
// driving stall, flush, per-operand forwarding selects and saturating event counters.
module pipe_hazard_unit #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned FWD_STAGES = 3,  // must be >= 2
  parameter int unsigned LOAD_LAT   = 2,
  parameter int unsigned FWD_EN     = 1,
  parameter int unsigned CNT_W      = 32
) (
  input logic               clock,
  input logic               reset,
  pipe_hazard_unit_if.slave hz
);
  localparam int unsigned FSW = $clog2(FWD_STAGES + 1);

  // Entry k holds the instruction k stages past ID (1=EX).
  logic [FWD_STAGES:1]               sbV, sbWr, sbLd;
  logic [FWD_STAGES:1][REG_AW-1:0]   sbRd;

  logic [FSW-1:0]   k, kA, kB, selA, selB;
  logic             ldA, ldB, hazA, hazB, stallInt, flushInt;
  logic [CNT_W-1:0] stallCnt, flushCnt;

  function automatic logic hit(input logic [FSW-1:0] stage, input logic [REG_AW-1:0] rs,
                               input logic used);
    return used && (rs != '0) && sbV[stage] && sbWr[stage] && (sbRd[stage] == rs);
  endfunction

  always_comb begin
    k   = '0;
    kA  = '0;
    kB  = '0;
    ldA = 1'b0;
    ldB = 1'b0;
    // Scan oldest to youngest so the youngest matching producer is kept last.
    for (int i = 0; i < int'(FWD_STAGES); i++) begin
      k = FSW'(int'(FWD_STAGES) - i);
      if (hit(k, hz.id_rs1, hz.id_use_rs1)) begin
        kA  = k;
        ldA = sbLd[k];
      end
      if (hit(k, hz.id_rs2, hz.id_use_rs2)) begin
        kB  = k;
        ldB = sbLd[k];
      end
    end

    if (FWD_EN != 0) begin
      hazA = (kA != '0) && ldA && (32'(kA) <= LOAD_LAT);
      hazB = (kB != '0) && ldB && (32'(kB) <= LOAD_LAT);
      selA = hazA ? '0 : kA;
      selB = hazB ? '0 : kB;
    end else begin
      // Write-through regfile covers the oldest stage; anything younger must wait.
      hazA = (kA != '0) && (32'(kA) < FWD_STAGES);
      hazB = (kB != '0) && (32'(kB) < FWD_STAGES);
      selA = '0;
      selB = '0;
    end

    stallInt = hz.id_valid && (hazA || hazB);
    flushInt = hz.id_branch_tk && !stallInt;
  end

  assign hz.stall       = stallInt;
  assign hz.pc_write    = !stallInt;
  assign hz.ifid_write  = !stallInt;
  assign hz.ifid_flush  = flushInt;
  assign hz.idex_bubble = stallInt;
  assign hz.fwd_sel_a   = selA;
  assign hz.fwd_sel_b   = selB;
  assign hz.stall_cnt   = stallCnt;
  assign hz.flush_cnt   = flushCnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      sbV  <= '0;
      sbWr <= '0;
      sbLd <= '0;
      sbRd <= '0;
    end else begin
      sbV  <= {sbV[FWD_STAGES-1:1], hz.id_valid && !stallInt};
      sbWr <= {sbWr[FWD_STAGES-1:1], hz.id_reg_write};
      sbLd <= {sbLd[FWD_STAGES-1:1], hz.id_mem_read};
      sbRd <= {sbRd[FWD_STAGES-1:1], hz.id_rd};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (stallInt && (stallCnt != '1)) stallCnt <= stallCnt + CNT_W'(1);
      if (flushInt && (flushCnt != '1)) flushCnt <= flushCnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: a forwarding instance and a stall-only instance with
// 2-bit counters, driven together and compared against an in-flight-list model.
module tb_pipe_hazard_unit;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic       idValid, idUse1, idUse2, idWr, idLd, idBr;
  logic [4:0] idRs1, idRs2, idRd;

  pipe_hazard_unit_if #(.REG_AW(5), .FWD_STAGES(3), .CNT_W(32)) ifF ();
  pipe_hazard_unit_if #(.REG_AW(5), .FWD_STAGES(3), .CNT_W(2))  ifS ();

  assign ifF.id_valid = idValid;     assign ifS.id_valid = idValid;
  assign ifF.id_rs1 = idRs1;         assign ifS.id_rs1 = idRs1;
  assign ifF.id_rs2 = idRs2;         assign ifS.id_rs2 = idRs2;
  assign ifF.id_use_rs1 = idUse1;    assign ifS.id_use_rs1 = idUse1;
  assign ifF.id_use_rs2 = idUse2;    assign ifS.id_use_rs2 = idUse2;
  assign ifF.id_rd = idRd;           assign ifS.id_rd = idRd;
  assign ifF.id_reg_write = idWr;    assign ifS.id_reg_write = idWr;
  assign ifF.id_mem_read = idLd;     assign ifS.id_mem_read = idLd;
  assign ifF.id_branch_tk = idBr;    assign ifS.id_branch_tk = idBr;

  pipe_hazard_unit #(
    .REG_AW(5), .FWD_STAGES(3), .LOAD_LAT(2), .FWD_EN(1), .CNT_W(32)
  ) dutF (
    .clock(clock), .reset(reset), .hz(ifF)
  );

  pipe_hazard_unit #(
    .REG_AW(5), .FWD_STAGES(3), .LOAD_LAT(2), .FWD_EN(0), .CNT_W(2)
  ) dutS (
    .clock(clock), .reset(reset), .hz(ifS)
  );

  // In-flight instructions per instance; index 0 is EX, 2 is WB.
  typedef struct {bit v; int rd; bit wr; bit ld;} ent_t;
  ent_t   pipe [2][3];
  longint mSc [2];
  longint mFc [2];
  longint cmax [2];
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int producer(input int d, input int rs, input bit used);
    if (!used || rs == 0) return 0;
    for (int s = 1; s <= 3; s++)
      if (pipe[d][s-1].v && pipe[d][s-1].wr && pipe[d][s-1].rd == rs) return s;
    return 0;
  endfunction

  function automatic bit blocks(input int d, input int s);
    if (s == 0) return 1'b0;
    if (d == 0) return pipe[d][s-1].ld && (s <= 2);
    return s < 3;
  endfunction

  function automatic int selOf(input int d, input int s);
    return (d == 0 && !blocks(d, s)) ? s : 0;
  endfunction

  task automatic clearModel();
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 3; s++) pipe[d][s] = '{1'b0, 0, 1'b0, 1'b0};
      mSc[d] = 0;
      mFc[d] = 0;
    end
  endtask

  task automatic advance(input int d, input bit st);
    pipe[d][2] = pipe[d][1];
    pipe[d][1] = pipe[d][0];
    pipe[d][0] = st ? '{1'b0, 0, 1'b0, 1'b0} : '{idValid, int'(idRd), idWr, idLd};
    if (st && mSc[d] < cmax[d]) mSc[d]++;
    if (idBr && !st && mFc[d] < cmax[d]) mFc[d]++;
  endtask

  task automatic checkDut(input int d, input logic st, input logic [1:0] sa, input logic [1:0] sb,
                          input logic pcw, input logic ifw, input logic fl, input logic bub,
                          input logic [63:0] sc, input logic [63:0] fc,
                          input bit eSt, input int eSa, input int eSb);
    chk($sformatf("d%0d stall", d), 64'(st), 64'(eSt));
    chk($sformatf("d%0d fwd_sel_a", d), 64'(sa), 64'(eSa));
    chk($sformatf("d%0d fwd_sel_b", d), 64'(sb), 64'(eSb));
    chk($sformatf("d%0d pc_write", d), 64'(pcw), 64'(!eSt));
    chk($sformatf("d%0d ifid_write", d), 64'(ifw), 64'(!eSt));
    chk($sformatf("d%0d ifid_flush", d), 64'(fl), 64'(idBr && !eSt));
    chk($sformatf("d%0d idex_bubble", d), 64'(bub), 64'(eSt));
    chk($sformatf("d%0d stall_cnt", d), sc, 64'(mSc[d]));
    chk($sformatf("d%0d flush_cnt", d), fc, 64'(mFc[d]));
  endtask

  // Check both instances mid-cycle, then update the model at the clock edge.
  task automatic step();
    bit st [2];
    int sa [2];
    int sb [2];
    int ka, kb;
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      ka    = producer(d, int'(idRs1), idUse1);
      kb    = producer(d, int'(idRs2), idUse2);
      st[d] = idValid && (blocks(d, ka) || blocks(d, kb));
      sa[d] = selOf(d, ka);
      sb[d] = selOf(d, kb);
    end
    checkDut(0, ifF.stall, ifF.fwd_sel_a, ifF.fwd_sel_b, ifF.pc_write, ifF.ifid_write,
             ifF.ifid_flush, ifF.idex_bubble, 64'(ifF.stall_cnt), 64'(ifF.flush_cnt),
             st[0], sa[0], sb[0]);
    checkDut(1, ifS.stall, ifS.fwd_sel_a, ifS.fwd_sel_b, ifS.pc_write, ifS.ifid_write,
             ifS.ifid_flush, ifS.idex_bubble, 64'(ifS.stall_cnt), 64'(ifS.flush_cnt),
             st[1], sa[1], sb[1]);
    @(posedge clock);
    if (reset) clearModel();
    else begin
      advance(0, st[0]);
      advance(1, st[1]);
    end
    #1;
  endtask

  task automatic setIns(input bit v, input int rd, input bit wr, input bit ld, input int rs1,
                        input bit u1, input int rs2, input bit u2, input bit br);
    idValid = v;  idRd = 5'(rd);   idWr = wr;     idLd = ld;
    idRs1 = 5'(rs1); idUse1 = u1;  idRs2 = 5'(rs2); idUse2 = u2; idBr = br;
  endtask

  task automatic drain();
    setIns(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) step();
  endtask

  initial begin
    cmax[0] = 64'hFFFF_FFFF;
    cmax[1] = 3;
    clearModel();
    reset = 1'b1;
    setIns(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clock);
    #1;
    step();
    reset = 1'b0;

    // Forward from EX, then from MEM on the next cycle.
    setIns(1, 5, 1, 0, 0, 0, 0, 0, 0); step();
    setIns(1, 6, 1, 0, 5, 1, 0, 0, 0);
    #1 chk("t1 sel EX", 64'(ifF.fwd_sel_a), 1);
    chk("t1 no stall", 64'(ifF.stall), 0);
    step();
    #1 chk("t1 sel MEM", 64'(ifF.fwd_sel_a), 2);
    step();
    drain();

    // Load-use: two stall cycles, then forward from WB on both operands.
    setIns(1, 5, 1, 1, 0, 0, 0, 0, 0); step();
    setIns(1, 6, 1, 0, 5, 1, 5, 1, 0);
    #1 chk("t2 stall c1", 64'(ifF.stall), 1);
    step();
    #1 chk("t2 stall c2", 64'(ifF.stall), 1);
    step();
    #1 chk("t2 released", 64'(ifF.stall), 0);
    chk("t2 sel a", 64'(ifF.fwd_sel_a), 3);
    chk("t2 sel b", 64'(ifF.fwd_sel_b), 3);
    chk("t2 stall_cnt", 64'(ifF.stall_cnt), 2);
    step();
    drain();
    chk("t6 stall_cnt saturated", 64'(ifS.stall_cnt), 3);

    // x0 never creates a dependency.
    setIns(1, 0, 1, 0, 0, 0, 0, 0, 0); step();
    setIns(1, 6, 1, 0, 0, 1, 0, 1, 0);
    #1 chk("t3 stall", 64'(ifF.stall), 0);
    chk("t3 sel a", 64'(ifF.fwd_sel_a), 0);
    chk("t3 sel b", 64'(ifS.fwd_sel_b), 0);
    step();
    drain();

    // Two producers of x7: the younger one wins.
    setIns(1, 7, 1, 0, 0, 0, 0, 0, 0); step(); step();
    setIns(1, 8, 1, 0, 7, 1, 0, 0, 0);
    #1 chk("t4 youngest", 64'(ifF.fwd_sel_a), 1);
    step();
    drain();

    // Taken branch waiting on a load: flush only once the stall clears.
    setIns(1, 5, 1, 1, 0, 0, 0, 0, 0); step();
    setIns(1, 0, 0, 0, 5, 1, 0, 0, 1);
    #1 chk("t5 no flush c1", 64'(ifF.ifid_flush), 0);
    step();
    #1 chk("t5 no flush c2", 64'(ifF.ifid_flush), 0);
    step();
    #1 chk("t5 flush", 64'(ifF.ifid_flush), 1);
    step();
    setIns(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("t5 flush_cnt", 64'(ifF.flush_cnt), 1);
    drain();

    // Stall-only mode: ALU dependency waits two cycles, then reads the regfile.
    setIns(1, 5, 1, 0, 0, 0, 0, 0, 0); step();
    setIns(1, 6, 1, 0, 5, 1, 0, 0, 0);
    #1 chk("t6 stall c1", 64'(ifS.stall), 1);
    step();
    #1 chk("t6 stall c2", 64'(ifS.stall), 1);
    step();
    #1 chk("t6 released", 64'(ifS.stall), 0);
    chk("t6 sel", 64'(ifS.fwd_sel_a), 0);
    step();
    drain();

    // Reset while a consumer is stalled clears the hazard.
    setIns(1, 5, 1, 1, 0, 0, 0, 0, 0); step();
    setIns(1, 6, 1, 0, 5, 1, 0, 0, 0);
    #1 chk("rst pre stall", 64'(ifF.stall), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1 chk("rst post stallF", 64'(ifF.stall), 0);
    chk("rst post stallS", 64'(ifS.stall), 0);
    chk("rst post cnt", 64'(ifF.stall_cnt), 0);
    step();
    drain();

    for (int n = 0; n < 400; n++) begin
      setIns($urandom_range(99) < 85, $urandom_range(7), $urandom_range(1),
             $urandom_range(99) < 30, $urandom_range(7), $urandom_range(1),
             $urandom_range(7), $urandom_range(1), $urandom_range(99) < 20);
      reset = ($urandom_range(99) < 2);
      step();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
